// File: rtl/program_memory_pkg.sv
// Shared definitions for the lab CPU program memory: opcode constants,
// the default fetch word, and the load/run FSM state encoding.
package program_memory_pkg;

    // Opcode field (top 4 bits of every instruction word)
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_LED  = 4'h1;
    localparam logic [3:0] OPC_CALL = 4'h2;
    localparam logic [3:0] OPC_RET  = 4'h3;
    localparam logic [3:0] OPC_JMP  = 4'h4;
    localparam logic [3:0] OPC_ADD  = 4'h5;

    localparam int PM_DATA_WIDTH = 28;

    // Word returned for any address that has not been loaded: LED pattern 0xAA
    localparam logic [PM_DATA_WIDTH-1:0] DEFAULT_WORD = {OPC_LED, 24'b10101010};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } pm_state_e;

endpackage

// File: rtl/program_memory_if.sv
// Fetch port (CPU side) and loader port (valid/ready) of the program memory.
interface program_memory_if #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] iAddress;
    logic                  iFetchEn;
    logic [DATA_WIDTH-1:0] oInstruction;
    logic                  oInstructionValid;
    logic                  iLoadStart;
    logic                  iLoadValid;
    logic [DATA_WIDTH-1:0] iLoadData;
    logic                  iLoadLast;
    logic                  oLoadReady;
    logic [ADDR_WIDTH:0]   oLoadCount;
    logic                  oLoadError;
    logic                  oRunning;

    modport slave (
        input  iAddress, iFetchEn, iLoadStart, iLoadValid, iLoadData, iLoadLast,
        output oInstruction, oInstructionValid, oLoadReady, oLoadCount, oLoadError, oRunning
    );

    modport master (
        output iAddress, iFetchEn, iLoadStart, iLoadValid, iLoadData, iLoadLast,
        input  oInstruction, oInstructionValid, oLoadReady, oLoadCount, oLoadError, oRunning
    );
endinterface

// File: rtl/program_memory_ram_dp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Contents are never reset; callers guarantee addresses are below DEPTH.
module program_ram_dp #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end

    // Registered read port; holds when not enabled
    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem_q[raddr_i[IDX_W-1:0]];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/program_memory.sv
// Field-loadable instruction memory: load FSM, word counter, overflow flag,
// and default-word muxing around a dual-port RAM.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_W = DATA_WIDTH'(DEFAULT_WORD)
) (
    input  logic             Clock,
    input  logic             Reset,
    program_memory_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    pm_state_e             state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  err_q, err_d;
    logic                  ready;
    logic                  xfer;
    logic                  rd_hit;
    logic                  hit_q;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Control state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Next-state: a start pulse always wins over a coincident transfer
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        xfer    = 1'b0;
        ready   = (state_q == ST_LOAD) && (count_q < DEPTH_C);
        case (state_q)
            ST_EMPTY, ST_RUN: begin
                if (bus.iLoadStart) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.iLoadStart) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (bus.iLoadValid && ready) begin
                    xfer    = 1'b1;
                    count_d = count_q + 1'b1;
                    if (bus.iLoadLast) begin
                        state_d = ST_RUN;
                    end else if (count_q + 1'b1 == DEPTH_C) begin
                        // Memory full without a last marker: run what we have, flag it
                        state_d = ST_RUN;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // A fetch only touches the RAM for loaded addresses in RUN; count never exceeds DEPTH
    assign rd_hit = (state_q == ST_RUN) && ({1'b0, bus.iAddress} < count_q);

    // Fetch qualifiers, aligned with the RAM read register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            vld_q <= 1'b0;
            hit_q <= 1'b0;
        end else if (bus.iFetchEn) begin
            vld_q <= (state_q == ST_RUN);
            hit_q <= rd_hit;
        end
    end

    program_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (xfer),
        .waddr_i (count_q[ADDR_WIDTH-1:0]),
        .wdata_i (bus.iLoadData),
        .re_i    (bus.iFetchEn && rd_hit),
        .raddr_i (bus.iAddress),
        .rdata_o (ram_rdata)
    );

    assign bus.oInstruction      = hit_q ? ram_rdata : DEFAULT_W;
    assign bus.oInstructionValid = vld_q;
    assign bus.oLoadReady        = ready;
    assign bus.oLoadCount        = count_q;
    assign bus.oLoadError        = err_q;
    assign bus.oRunning          = (state_q == ST_RUN);

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: a full-depth instance (A) and a
// DEPTH=4 instance (B) for the overflow and restart scenarios.
module tb_program_memory;

    localparam logic [27:0] DEF = 28'h10000AA;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 Clock = ~Clock;

    program_memory_if #(.DATA_WIDTH(28), .ADDR_WIDTH(8)) ifa ();
    program_memory_if #(.DATA_WIDTH(28), .ADDR_WIDTH(8)) ifb ();

    program_memory #(.DATA_WIDTH(28), .ADDR_WIDTH(8), .DEPTH(256)) dut_a (
        .Clock (Clock), .Reset (Reset), .bus (ifa.slave));
    program_memory #(.DATA_WIDTH(28), .ADDR_WIDTH(8), .DEPTH(4)) dut_b (
        .Clock (Clock), .Reset (Reset), .bus (ifb.slave));

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // ---- stimulus helpers (no checking) ----
    task automatic start(input bit b);
        if (b) ifb.iLoadStart = 1'b1; else ifa.iLoadStart = 1'b1;
        tick();
        ifa.iLoadStart = 1'b0;
        ifb.iLoadStart = 1'b0;
    endtask

    task automatic push(input bit b, input logic [27:0] d, input logic last);
        if (b) begin
            ifb.iLoadValid = 1'b1; ifb.iLoadData = d; ifb.iLoadLast = last;
        end else begin
            ifa.iLoadValid = 1'b1; ifa.iLoadData = d; ifa.iLoadLast = last;
        end
        tick();
    endtask

    task automatic idle();
        ifa.iLoadValid = 1'b0; ifa.iLoadLast = 1'b0;
        ifb.iLoadValid = 1'b0; ifb.iLoadLast = 1'b0;
    endtask

    task automatic fetch(input bit b, input logic [7:0] addr);
        if (b) begin ifb.iFetchEn = 1'b1; ifb.iAddress = addr; end
        else   begin ifa.iFetchEn = 1'b1; ifa.iAddress = addr; end
        tick();
        ifa.iFetchEn = 1'b0;
        ifb.iFetchEn = 1'b0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        #12;
        checks++; if (ifa.oInstruction !== DEF) begin errors++; $display("FAIL reset_instr got %h want %h", ifa.oInstruction, DEF); end
        checks++; if (ifa.oInstructionValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ifa.oInstructionValid); end
        checks++; if (ifa.oLoadReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ifa.oLoadReady); end
        checks++; if (ifa.oRunning !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", ifa.oRunning); end
        checks++; if (ifa.oLoadCount !== 9'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ifa.oLoadCount); end
        checks++; if (ifa.oLoadError !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", ifa.oLoadError); end
        checks++; if (ifb.oInstruction !== DEF) begin errors++; $display("FAIL reset_instr_b got %h want %h", ifb.oInstruction, DEF); end
        Reset = 1'b1;
        tick();
        // Fetch while EMPTY: default word, not valid
        fetch(0, 8'd0);
        checks++; if (ifa.oInstruction !== DEF || ifa.oInstructionValid !== 1'b0) begin errors++; $display("FAIL empty_fetch got %h/%b want %h/0", ifa.oInstruction, ifa.oInstructionValid, DEF); end
    endtask

    task automatic test_load3();
        logic [27:0] w [4];
        w[0] = 28'h1000000; w[1] = 28'h2123456; w[2] = 28'h3ABCDEF; w[3] = DEF;
        start(0);
        checks++; if (ifa.oLoadReady !== 1'b1) begin errors++; $display("FAIL load3_ready got %b want 1", ifa.oLoadReady); end
        checks++; if (ifa.oLoadCount !== 9'd0) begin errors++; $display("FAIL load3_count0 got %0d want 0", ifa.oLoadCount); end
        for (int i = 0; i < 3; i++) begin
            push(0, w[i], i == 2);
            checks++; if (ifa.oLoadCount !== 9'(i + 1)) begin errors++; $display("FAIL load3_count got %0d want %0d", ifa.oLoadCount, i + 1); end
            checks++; if (ifa.oRunning !== (i == 2)) begin errors++; $display("FAIL load3_running got %b want %b", ifa.oRunning, (i == 2)); end
        end
        idle();
        checks++; if (ifa.oLoadReady !== 1'b0) begin errors++; $display("FAIL load3_ready_run got %b want 0", ifa.oLoadReady); end
        // Back-to-back fetches, one per cycle
        ifa.iFetchEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifa.iAddress = 8'(i);
            tick();
            checks++; if (ifa.oInstruction !== w[i]) begin errors++; $display("FAIL load3_fetch got %h want %h", ifa.oInstruction, w[i]); end
            checks++; if (ifa.oInstructionValid !== 1'b1) begin errors++; $display("FAIL load3_valid got %b want 1", ifa.oInstructionValid); end
        end
        ifa.iFetchEn = 1'b0;
        fetch(0, 8'd1);
        checks++; if (ifa.oInstruction !== w[1]) begin errors++; $display("FAIL load3_refetch got %h want %h", ifa.oInstruction, w[1]); end
        // Fetch disabled: output holds even though the address changes
        ifa.iAddress = 8'd2;
        tick();
        checks++; if (ifa.oInstruction !== w[1] || ifa.oInstructionValid !== 1'b1) begin errors++; $display("FAIL load3_hold got %h want %h", ifa.oInstruction, w[1]); end
        fetch(0, 8'd200);
        checks++; if (ifa.oInstruction !== DEF) begin errors++; $display("FAIL load3_far got %h want %h", ifa.oInstruction, DEF); end
    endtask

    task automatic test_toggle();
        logic [27:0] t [5];
        t[0] = 28'h5000001; t[1] = 28'h6000002; t[2] = 28'h7000003; t[3] = 28'h8000004; t[4] = DEF;
        start(0);
        for (int i = 0; i < 4; i++) begin
            push(0, t[i], i == 3);
            checks++; if (ifa.oLoadCount !== 9'(i + 1)) begin errors++; $display("FAIL toggle_count got %0d want %0d", ifa.oLoadCount, i + 1); end
            if (i < 3) begin
                ifa.iLoadValid = 1'b0;
                ifa.iLoadData  = 28'hFFFFFFF;
                tick();
                checks++; if (ifa.oLoadCount !== 9'(i + 1)) begin errors++; $display("FAIL toggle_gap got %0d want %0d", ifa.oLoadCount, i + 1); end
            end
        end
        idle();
        checks++; if (ifa.oRunning !== 1'b1) begin errors++; $display("FAIL toggle_running got %b want 1", ifa.oRunning); end
        for (int i = 0; i < 5; i++) begin
            fetch(0, 8'(i));
            checks++; if (ifa.oInstruction !== t[i]) begin errors++; $display("FAIL toggle_fetch got %h want %h", ifa.oInstruction, t[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [27:0] o [6];
        logic [8:0]  exp_cnt;
        for (int i = 0; i < 6; i++) o[i] = 28'h9000010 + 28'(i);
        start(1);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                checks++; if (ifb.oLoadReady !== 1'b1) begin errors++; $display("FAIL ovf_ready3 got %b want 1", ifb.oLoadReady); end
            end
            push(1, o[i], 1'b0);
            exp_cnt = (i < 4) ? 9'(i + 1) : 9'd4;
            checks++; if (ifb.oLoadCount !== exp_cnt) begin errors++; $display("FAIL ovf_count got %0d want %0d", ifb.oLoadCount, exp_cnt); end
        end
        idle();
        checks++; if (ifb.oLoadReady !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b want 0", ifb.oLoadReady); end
        checks++; if (ifb.oLoadError !== 1'b1) begin errors++; $display("FAIL ovf_error got %b want 1", ifb.oLoadError); end
        checks++; if (ifb.oRunning !== 1'b1) begin errors++; $display("FAIL ovf_running got %b want 1", ifb.oRunning); end
        for (int i = 0; i < 4; i++) begin
            fetch(1, 8'(i));
            checks++; if (ifb.oInstruction !== o[i]) begin errors++; $display("FAIL ovf_fetch got %h want %h", ifb.oInstruction, o[i]); end
        end
        fetch(1, 8'd4);
        checks++; if (ifb.oInstruction !== DEF) begin errors++; $display("FAIL ovf_fetch4 got %h want %h", ifb.oInstruction, DEF); end
        fetch(1, 8'd255);
        checks++; if (ifb.oInstruction !== DEF) begin errors++; $display("FAIL ovf_fetch255 got %h want %h", ifb.oInstruction, DEF); end
    endtask

    task automatic test_restart();
        logic [27:0] n [4];
        n[0] = 28'hA000001; n[1] = 28'hB000002; n[2] = 28'hC000003; n[3] = DEF;
        start(1);
        checks++; if (ifb.oLoadError !== 1'b0) begin errors++; $display("FAIL restart_errclr got %b want 0", ifb.oLoadError); end
        push(1, 28'hD0000AA, 1'b0);
        push(1, 28'hD0000BB, 1'b0);
        checks++; if (ifb.oLoadCount !== 9'd2) begin errors++; $display("FAIL restart_count2 got %0d want 2", ifb.oLoadCount); end
        // Start coincident with a transfer: start wins, word dropped
        ifb.iLoadStart = 1'b1; ifb.iLoadValid = 1'b1; ifb.iLoadData = 28'hEEEEEEE; ifb.iLoadLast = 1'b1;
        tick();
        ifb.iLoadStart = 1'b0;
        idle();
        checks++; if (ifb.oLoadCount !== 9'd0) begin errors++; $display("FAIL restart_count0 got %0d want 0", ifb.oLoadCount); end
        checks++; if (ifb.oRunning !== 1'b0 || ifb.oLoadReady !== 1'b1) begin errors++; $display("FAIL restart_state got run=%b rdy=%b want 0/1", ifb.oRunning, ifb.oLoadReady); end
        fetch(1, 8'd0);
        checks++; if (ifb.oInstruction !== DEF || ifb.oInstructionValid !== 1'b0) begin errors++; $display("FAIL restart_loadfetch got %h/%b want %h/0", ifb.oInstruction, ifb.oInstructionValid, DEF); end
        for (int i = 0; i < 3; i++) push(1, n[i], i == 2);
        idle();
        checks++; if (ifb.oLoadCount !== 9'd3 || ifb.oLoadError !== 1'b0) begin errors++; $display("FAIL restart_done got %0d/%b want 3/0", ifb.oLoadCount, ifb.oLoadError); end
        for (int i = 0; i < 4; i++) begin
            fetch(1, 8'(i));
            checks++; if (ifb.oInstruction !== n[i]) begin errors++; $display("FAIL restart_fetch got %h want %h", ifb.oInstruction, n[i]); end
        end
    endtask

    task automatic test_reset_midload();
        logic [27:0] m [3];
        m[0] = 28'h2000042; m[1] = 28'h3000043; m[2] = DEF;
        start(0);
        for (int i = 0; i < 5; i++) push(0, 28'h4000000 + 28'(i), 1'b0);
        idle();
        checks++; if (ifa.oLoadCount !== 9'd5) begin errors++; $display("FAIL mid_count5 got %0d want 5", ifa.oLoadCount); end
        #2 Reset = 1'b0;
        #1;
        checks++; if (ifa.oLoadCount !== 9'd0) begin errors++; $display("FAIL mid_count0 got %0d want 0", ifa.oLoadCount); end
        checks++; if (ifa.oLoadReady !== 1'b0 || ifa.oRunning !== 1'b0) begin errors++; $display("FAIL mid_state got rdy=%b run=%b want 0/0", ifa.oLoadReady, ifa.oRunning); end
        checks++; if (ifa.oInstruction !== DEF || ifa.oInstructionValid !== 1'b0) begin errors++; $display("FAIL mid_out got %h/%b want %h/0", ifa.oInstruction, ifa.oInstructionValid, DEF); end
        #1 Reset = 1'b1;
        fetch(0, 8'd0);
        checks++; if (ifa.oInstruction !== DEF || ifa.oInstructionValid !== 1'b0) begin errors++; $display("FAIL mid_fetch got %h/%b want %h/0", ifa.oInstruction, ifa.oInstructionValid, DEF); end
        start(0);
        push(0, m[0], 1'b0);
        push(0, m[1], 1'b1);
        idle();
        checks++; if (ifa.oRunning !== 1'b1 || ifa.oLoadCount !== 9'd2) begin errors++; $display("FAIL mid_reload got run=%b cnt=%0d want 1/2", ifa.oRunning, ifa.oLoadCount); end
        for (int i = 0; i < 3; i++) begin
            fetch(0, 8'(i));
            checks++; if (ifa.oInstruction !== m[i] || ifa.oInstructionValid !== 1'b1) begin errors++; $display("FAIL mid_refetch got %h want %h", ifa.oInstruction, m[i]); end
        end
    endtask

    initial begin
        ifa.iAddress = '0; ifa.iFetchEn = 1'b0; ifa.iLoadStart = 1'b0;
        ifa.iLoadValid = 1'b0; ifa.iLoadData = '0; ifa.iLoadLast = 1'b0;
        ifb.iAddress = '0; ifb.iFetchEn = 1'b0; ifb.iLoadStart = 1'b0;
        ifb.iLoadValid = 1'b0; ifb.iLoadData = '0; ifb.iLoadLast = 1'b0;
        test_reset();
        test_load3();
        test_toggle();
        test_overflow();
        test_restart();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
